// File: rtl/ram_writer_pkg.sv
// Shared types and defaults for the RAM writer block.
//   wr_state_t  : controller state encoding (IDLE, WRITE, DONE)
//   addr_width  : address width for a given depth (never less than 1 bit)
package ram_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DATA_DEPTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_writer_controller_ram_array.sv
// ram_array: synchronous RAM, one write port and one registered read port.
// Read-first: a read and a write to the same address on the same edge
// return the word stored before that edge.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears rdata only)
//   we, waddr, wdata   write port
//   re, raddr    read request; out-of-range addresses read back as 0
//   rdata        registered read data, holds when re=0
module ram_array
  import ram_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  localparam int ADDR_WIDTH = addr_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] memory [DATA_DEPTH];

  // Contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      memory[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if ({1'b0, raddr} < DEPTH_EXT) begin
        rdata <= memory[raddr];
      end else begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/ram_writer_controller.sv
// ram_writer_controller: after a start pulse, sinks exactly DATA_DEPTH words
// from a valid/ready stream into an internal RAM at sequential addresses,
// then pulses done. A registered random-access read port exposes the RAM.
//
// Optional build macro RAM_WRITER_CHECKSUM_EN adds a checksum output holding
// the modulo-2^DATA_WIDTH sum of the words accepted in the current transfer.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a fill (honoured only in IDLE)
//   in_valid, in_data  upstream word
//   in_ready           high while in WRITE
//   busy               high while in WRITE
//   done               one-cycle pulse after the last word is written
//   wr_count           words written in the current/last transfer
//   rd_en, rd_addr     read request
//   rd_data            read data, one cycle after rd_en
//   checksum           (RAM_WRITER_CHECKSUM_EN only) running word sum
//
// state | meaning
// IDLE  | waiting for start, in_ready low
// WRITE | accepting words, one per in_valid cycle
// DONE  | last word written, done high for this one cycle
module ram_writer_controller
  import ram_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  localparam int ADDR_WIDTH = addr_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef RAM_WRITER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  wr_state_t             state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  accept;

  assign in_ready = (state == WRITE);
  assign busy     = (state == WRITE);
  // A word presented on a reset edge is dropped along with the transfer.
  assign accept   = in_ready && in_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_addr  <= '0;
      wr_count <= '0;
      done     <= 1'b0;
`ifdef RAM_WRITER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WRITE;
            wr_addr  <= '0;
            wr_count <= '0;
`ifdef RAM_WRITER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        WRITE: begin
          if (in_valid) begin
            wr_count <= wr_count + 1'b1;
`ifdef RAM_WRITER_CHECKSUM_EN
            checksum <= checksum + in_data;
`endif
            // Address parks on the last slot rather than wrapping.
            if (wr_addr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH)
  ) ram_inst (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .waddr(wr_addr),
    .wdata(in_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_ram_writer_controller.sv
module tb_ram_writer_controller;

  localparam int DW    = 16;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
`ifdef RAM_WRITER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_writer_controller #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
    .wr_count(wr_count),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef RAM_WRITER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_pulses = 0;
  int last_done   = -1;
  int ready_cyc   = 0;

  // Transfer-level reference: "filling" phase, words taken so far, and the
  // words that should sit in each RAM slot.
  bit            m_filling = 0;
  bit            m_done    = 0;
  int            m_taken   = 0;
  logic [DW-1:0] m_sum     = '0;
  logic [DW-1:0] m_rd      = '0;
  logic [DW-1:0] model_mem [DEPTH];

  // Checks the DUT against the reference for the current cycle, applies one
  // cycle of inputs, advances the reference, and moves to the next negedge.
  task automatic cycle(input logic s, input logic v, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic r);
    logic [DW-1:0] nxt_rd;
    bit            nxt_done;
    vectors++;
    if (in_ready !== m_filling) begin
      miscompares++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_filling);
    end
    vectors++;
    if (busy !== m_filling) begin
      miscompares++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_filling);
    end
    vectors++;
    if (done !== m_done) begin
      miscompares++;
      $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, m_done);
    end
    vectors++;
    if (wr_count !== (AW+1)'(m_taken)) begin
      miscompares++;
      $display("FAIL wr_count cyc=%0d got=%0d exp=%0d", cyc, wr_count, m_taken);
    end
    vectors++;
    if (rd_data !== m_rd) begin
      miscompares++;
      $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rd_data, m_rd);
    end
`ifdef RAM_WRITER_CHECKSUM_EN
    vectors++;
    if (checksum !== m_sum) begin
      miscompares++;
      $display("FAIL checksum cyc=%0d got=%h exp=%h", cyc, checksum, m_sum);
    end
`endif
    if (done === 1'b1) begin
      done_pulses++;
      last_done = cyc;
    end
    if (in_ready === 1'b1) ready_cyc++;

    start = s; in_valid = v; in_data = d; rd_en = re; rd_addr = ra; rst = r;

    nxt_rd = m_rd;
    if (r) nxt_rd = '0;
    else if (re) nxt_rd = (int'(ra) < DEPTH) ? model_mem[ra] : '0;

    nxt_done = 0;
    if (r) begin
      m_filling = 0; m_taken = 0; m_sum = '0;
    end else if (m_filling && v) begin
      model_mem[m_taken] = d;
      m_sum = m_sum + d;
      m_taken++;
      if (m_taken == DEPTH) begin
        m_filling = 0;
        nxt_done  = 1;
      end
    end else if (!m_filling && !m_done && s) begin
      m_filling = 1; m_taken = 0; m_sum = '0;
    end
    m_done = nxt_done;
    m_rd   = nxt_rd;

    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, '0, 0, '0, 1);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b%b%b exp=000", in_ready, busy, done);
    end
    vectors++;
    if (wr_count !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got wr_count=%0d rd_data=%h exp 0/0", wr_count, rd_data);
    end
  endtask

  task automatic test_basic_fill();
    int c0, p0, r0;
    c0 = cyc; p0 = done_pulses; r0 = ready_cyc;
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, DW'(i + 1), 0, '0, 0);
    idle(3);
    vectors++;
    if (done_pulses - p0 != 1 || last_done - c0 != DEPTH + 1) begin
      miscompares++;
      $display("FAIL basic_done got pulses=%0d at=%0d exp 1 at %0d",
               done_pulses - p0, last_done - c0, DEPTH + 1);
    end
    vectors++;
    if (ready_cyc - r0 != DEPTH) begin
      miscompares++;
      $display("FAIL basic_ready got=%0d exp=%0d", ready_cyc - r0, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dut.ram_inst.memory[i] !== DW'(i + 1)) begin
        miscompares++;
        $display("FAIL basic_mem[%0d] got=%h exp=%h", i, dut.ram_inst.memory[i], DW'(i + 1));
      end
    end
    vectors++;
    if (wr_count !== (AW+1)'(DEPTH)) begin
      miscompares++;
      $display("FAIL basic_count got=%0d exp=%0d", wr_count, DEPTH);
    end
  endtask

  task automatic test_stalled();
    int p0;
    p0 = done_pulses;
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 16'hA000 + DW'(i), 0, '0, 0);
      idle(2);
    end
    idle(2);
    vectors++;
    if (done_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL stall_done got=%0d exp=1", done_pulses - p0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dut.ram_inst.memory[i] !== 16'hA000 + DW'(i)) begin
        miscompares++;
        $display("FAIL stall_mem[%0d] got=%h exp=%h", i, dut.ram_inst.memory[i], 16'hA000 + DW'(i));
      end
    end
  endtask

  task automatic test_ignored_start_overflow();
    int p0, c0, r0;
    p0 = done_pulses; c0 = cyc;
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(i == 2, 1, 16'h5500 + DW'(i), 0, '0, 0);
    r0 = ready_cyc;
    for (int i = 0; i < 5; i++) cycle(0, 1, 16'hFFFF, 0, '0, 0);
    idle(1);
    vectors++;
    if (done_pulses - p0 != 1 || last_done - c0 != DEPTH + 1) begin
      miscompares++;
      $display("FAIL restart_done got pulses=%0d at=%0d exp 1 at %0d",
               done_pulses - p0, last_done - c0, DEPTH + 1);
    end
    vectors++;
    if (ready_cyc != r0) begin
      miscompares++;
      $display("FAIL overflow_ready got=%0d exp=0", ready_cyc - r0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dut.ram_inst.memory[i] !== 16'h5500 + DW'(i)) begin
        miscompares++;
        $display("FAIL overflow_mem[%0d] got=%h exp=%h", i, dut.ram_inst.memory[i], 16'h5500 + DW'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = done_pulses;
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0C00 + DW'(i), 0, '0, 0);
    cycle(0, 1, 16'h0C03, 0, '0, 1);
    idle(3);
    vectors++;
    if (done_pulses != p0) begin
      miscompares++;
      $display("FAIL abort_done got=%0d exp=0", done_pulses - p0);
    end
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'h0B00 + DW'(i), 0, '0, 0);
    idle(2);
    vectors++;
    if (done_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL refill_done got=%0d exp=1", done_pulses - p0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dut.ram_inst.memory[i] !== 16'h0B00 + DW'(i)) begin
        miscompares++;
        $display("FAIL refill_mem[%0d] got=%h exp=%h", i, dut.ram_inst.memory[i], 16'h0B00 + DW'(i));
      end
    end
  endtask

  task automatic test_read_port();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, '0, 1, AW'(i), 0);
      vectors++;
      if (rd_data !== 16'h0B00 + DW'(i)) begin
        miscompares++;
        $display("FAIL read[%0d] got=%h exp=%h", i, rd_data, 16'h0B00 + DW'(i));
      end
    end
    cycle(0, 0, '0, 1, 3'd7, 0);
    vectors++;
    if (rd_data !== '0) begin
      miscompares++;
      $display("FAIL read_oob got=%h exp=0000", rd_data);
    end
    cycle(0, 0, '0, 1, 3'd2, 0);
    cycle(0, 0, '0, 0, 3'd4, 0);
    vectors++;
    if (rd_data !== 16'h0B02) begin
      miscompares++;
      $display("FAIL read_hold got=%h exp=0b02", rd_data);
    end
    cycle(1, 0, '0, 0, '0, 0);
    cycle(0, 1, 16'hD000, 1, 3'd0, 0);
    vectors++;
    if (rd_data !== 16'h0B00) begin
      miscompares++;
      $display("FAIL read_first got=%h exp=0b00", rd_data);
    end
    for (int i = 1; i < DEPTH; i++) cycle(0, 1, 16'hD000 + DW'(i), 0, '0, 0);
    idle(2);
  endtask

  task automatic test_random();
    logic s, v, re, r;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    int p0;
    p0 = done_pulses;
    for (int n = 0; n < 1500; n++) begin
      s  = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 9) < 6);
      d  = DW'($urandom);
      re = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 7));
      r  = ($urandom_range(0, 299) == 0);
      cycle(s, v, d, re, ra, r);
    end
    cycle(0, 0, '0, 0, '0, 1);
    vectors++;
    if (done_pulses == p0) begin
      miscompares++;
      $display("FAIL random_done got=0 exp>0");
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dut.ram_inst.memory[i] !== model_mem[i]) begin
        miscompares++;
        $display("FAIL random_mem[%0d] got=%h exp=%h", i, dut.ram_inst.memory[i], model_mem[i]);
      end
    end
  endtask

`ifdef RAM_WRITER_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] words [DEPTH];
    words = '{16'h8000, 16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    cycle(0, 0, '0, 0, '0, 1);
    cycle(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, words[i], 0, '0, 0);
    vectors++;
    if (done !== 1'b1 || checksum !== 16'h000A) begin
      miscompares++;
      $display("FAIL checksum_done got done=%b sum=%h exp done=1 sum=000a", done, checksum);
    end
    idle(2);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic_fill();
    test_stalled();
    test_ignored_start_overflow();
    test_reset_mid();
    test_read_port();
    test_random();
`ifdef RAM_WRITER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
